// File: rtl/cpu_if_fetch.sv
// Instruction-fetch stage: fetch PC, req/gnt/rvalid bus master, in-order word buffer
// feeding ID, redirect flush handling and misaligned-fetch exception entries.
module cpu_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        adel_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_EXC = 1'b1} state_t;

  state_t        state_r;
  logic          active_r;
  logic [31:0]   pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] count_r;
  logic [IW-1:0] rd_ptr_r;
  logic [IW-1:0] wr_ptr_r;
  logic [IW-1:0] tag_rd_r;
  logic [IW-1:0] tag_wr_r;
  logic [31:0]   buf_pc_r   [DEPTH];
  logic [31:0]   buf_inst_r [DEPTH];
  logic          buf_adel_r [DEPTH];
  logic [31:0]   tag_pc_r   [DEPTH];

  logic [CW:0]   credit_s;
  logic          req_s;
  logic          hs_s;
  logic          drop_word_s;
  logic          rsp_push_s;
  logic          exc_push_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] inflight_next_s;
  logic [31:0]   push_pc_s;
  logic [31:0]   push_inst_s;
  logic          push_adel_s;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (p == IW'(DEPTH - 1)) begin
      ptr_inc = {IW{1'b0}};
    end else begin
      ptr_inc = p + IW'(1);
    end
  endfunction

  // Issue, response routing and buffer push/pop decisions.
  always_comb begin
    credit_s        = {1'b0, inflight_r} + {1'b0, count_r};
    req_s           = active_r && (state_r == ST_RUN) && !flush_i &&
                      (pc_r[1:0] == 2'b00) && (credit_s < (CW+1)'(DEPTH));
    hs_s            = req_s && ibus_gnt_i;
    // A response racing a flush belongs to the old stream and is dropped too.
    drop_word_s     = ibus_rvalid_i && (flush_i || (drop_r != {CW{1'b0}}));
    rsp_push_s      = ibus_rvalid_i && !drop_word_s;
    exc_push_s      = active_r && (state_r == ST_RUN) && !flush_i &&
                      (pc_r[1:0] != 2'b00) && (inflight_r == {CW{1'b0}}) &&
                      (count_r == {CW{1'b0}});
    push_s          = rsp_push_s || exc_push_s;
    pop_s           = (count_r != {CW{1'b0}}) && !stall_i && !flush_i;
    inflight_next_s = inflight_r + CW'(hs_s) - CW'(ibus_rvalid_i);
    if (rsp_push_s) begin
      push_pc_s   = tag_pc_r[tag_rd_r];
      push_inst_s = ibus_rdata_i;
      push_adel_s = 1'b0;
    end else begin
      push_pc_s   = pc_r;
      push_inst_s = 32'h0000_0000;
      push_adel_s = exc_push_s;
    end
  end

  // Head-of-buffer presentation; payload forced to zero when empty.
  always_comb begin
    ibus_req_o  = req_s;
    ibus_addr_o = pc_r;
    valid_o     = (count_r != {CW{1'b0}});
    if (valid_o) begin
      pc_o   = buf_pc_r[rd_ptr_r];
      inst_o = buf_inst_r[rd_ptr_r];
      adel_o = buf_adel_r[rd_ptr_r];
    end else begin
      pc_o   = 32'h0000_0000;
      inst_o = 32'h0000_0000;
      adel_o = 1'b0;
    end
  end

  // Control state: FSM, fetch PC, credit counters and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      active_r   <= 1'b0;
      pc_r       <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      drop_r     <= {CW{1'b0}};
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {IW{1'b0}};
      wr_ptr_r   <= {IW{1'b0}};
      tag_rd_r   <= {IW{1'b0}};
      tag_wr_r   <= {IW{1'b0}};
    end else begin
      active_r   <= 1'b1;
      inflight_r <= inflight_next_s;
      if (flush_i) begin
        state_r  <= ST_RUN;
        pc_r     <= redirect_pc_i;
        drop_r   <= inflight_next_s;
        count_r  <= {CW{1'b0}};
        rd_ptr_r <= {IW{1'b0}};
        wr_ptr_r <= {IW{1'b0}};
      end else begin
        case (state_r)
          ST_RUN:  state_r <= exc_push_s ? ST_EXC : ST_RUN;
          ST_EXC:  state_r <= ST_EXC;
          default: state_r <= ST_RUN;
        endcase
        if (hs_s) begin
          pc_r <= pc_r + 32'd4;
        end
        if (ibus_rvalid_i && (drop_r != {CW{1'b0}})) begin
          drop_r <= drop_r - CW'(1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
        if (push_s) begin
          wr_ptr_r <= ptr_inc(wr_ptr_r);
        end
        if (pop_s) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
      end
      // The tag queue tracks every outstanding request, flushed or not.
      if (ibus_rvalid_i) begin
        tag_rd_r <= ptr_inc(tag_rd_r);
      end
      if (hs_s) begin
        tag_wr_r <= ptr_inc(tag_wr_r);
      end
    end
  end

  // Buffer payload and per-request PC tag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_r[i]   <= 32'h0000_0000;
        buf_inst_r[i] <= 32'h0000_0000;
        buf_adel_r[i] <= 1'b0;
        tag_pc_r[i]   <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        buf_pc_r[wr_ptr_r]   <= push_pc_s;
        buf_inst_r[wr_ptr_r] <= push_inst_s;
        buf_adel_r[wr_ptr_r] <= push_adel_s;
      end
      if (hs_s) begin
        tag_pc_r[tag_wr_r] <= pc_r;
      end
    end
  end
endmodule

// File: tb/tb_cpu_if_fetch.sv
// Scoreboard bench for cpu_if_fetch: a bus model returns words in order and
// expected {pc, inst, adel} entries are compared as ID consumes them.
module tb_cpu_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        adel_o;

  cpu_if_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .adel_o(adel_o)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          first_hs = -1;
  int          first_valid = -1;
  logic        gnt_en = 1'b0;
  logic        rsp_en = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] last_pop_pc = 32'h0;
  logic [31:0] resp_q[$];
  int          resp_t[$];
  exp_t        exp_q[$];
  logic        s_req, s_valid, s_adel;
  logic [31:0] s_pc, s_inst;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h3c1a_5e07;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, update the reference model.
  task automatic step(input logic st, input logic fl, input logic [31:0] rpc);
    logic hs, pop, rv;
    exp_t e;
    @(negedge clk);
    stall_i       = st;
    flush_i       = fl;
    redirect_pc_i = rpc;
    rv            = rsp_en && (resp_q.size() > 0) && (resp_t.size() > 0) && (resp_t[0] < cyc);
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rv ? word_of(resp_q[0]) : 32'h0;
    ibus_gnt_i    = gnt_en;
    #1;
    s_req = ibus_req_o; s_valid = valid_o; s_pc = pc_o; s_inst = inst_o; s_adel = adel_o;
    hs  = ibus_req_o && ibus_gnt_i;
    pop = valid_o && !st && !fl;
    if (prev_flush) begin
      check_val("valid_after_flush", valid_o, 0);
      check_val("inst_after_flush", inst_o, 0);
    end
    if (fl) check_val("req_during_flush", ibus_req_o, 0);
    if (exp_pc[1:0] != 2'b00) check_val("req_misaligned", ibus_req_o, 0);
    if (ibus_req_o) check_val("addr", ibus_addr_o, exp_pc);
    if (hs && first_hs < 0) first_hs = cyc;
    if (valid_o && first_valid < 0) first_valid = cyc;
    if (pop) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", pc_o, 64'hffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check_val("pc", pc_o, e.pc);
        check_val("inst", inst_o, e.inst);
        check_val("adel", adel_o, e.adel);
      end
      n_pop++;
      last_pop_pc = pc_o;
    end
    if (rv) begin
      void'(resp_q.pop_front());
      void'(resp_t.pop_front());
    end
    if (hs) begin
      resp_q.push_back(ibus_addr_o);
      resp_t.push_back(cyc);
      exp_q.push_back('{pc: ibus_addr_o, inst: word_of(ibus_addr_o), adel: 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    if (fl) begin
      exp_q.delete();
      exp_pc = rpc;
    end
    prev_flush = fl;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_until_pop(input string tag, input logic [31:0] want_pc);
    int start;
    start = n_pop;
    for (int k = 0; k < 30 && n_pop == start; k++) step(1'b0, 1'b0, 32'h0);
    check_val({tag, "_timeout"}, n_pop > start, 1);
    check_val({tag, "_pc"}, last_pop_pc, want_pc);
  endtask

  task automatic fill_inflight(input string tag);
    rsp_en = 1'b0;
    gnt_en = 1'b1;
    for (int k = 0; k < 20 && resp_q.size() < 2; k++) step(1'b0, 1'b0, 32'h0);
    check_val({tag, "_inflight2"}, resp_q.size(), 2);
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic        hold_seen;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_pc_i = 32'h0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req", ibus_req_o, 0);
    check_val("rst_valid", valid_o, 0);
    check_val("rst_pc", pc_o, 0);
    check_val("rst_inst", inst_o, 0);
    check_val("rst_adel", adel_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch from reset
    gnt_en = 1'b1; rsp_en = 1'b1;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'h0);
    check_val("first_valid_latency", first_valid - first_hs, 2);
    check_val("seen_grant", first_hs >= 0, 1);

    // Downstream stall: credit limit and steady head
    hold_seen = 1'b0; hold_pc = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check_val("credit_limit", exp_q.size() <= 2, 1);
      if (s_valid && !hold_seen) begin hold_seen = 1'b1; hold_pc = s_pc; end
      else if (s_valid) check_val("stall_head_pc", s_pc, hold_pc);
    end
    check_val("stall_head_seen", hold_seen, 1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0);

    // Flush with two requests outstanding
    fill_inflight("f1");
    step(1'b0, 1'b1, 32'h8000_0100);
    rsp_en = 1'b1;
    run_until_pop("flush1", 32'h8000_0100);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0);

    // Flush coinciding with gnt and rvalid
    fill_inflight("f2");
    rsp_en = 1'b1;
    step(1'b0, 1'b1, 32'h8000_0200);
    run_until_pop("flush2", 32'h8000_0200);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0);

    // Misaligned redirect: exception entry held under stall
    gnt_en = 1'b0;
    for (int k = 0; k < 10 && resp_q.size() > 0; k++) step(1'b1, 1'b0, 32'h0);
    check_val("drain_before_exc", resp_q.size(), 0);
    gnt_en = 1'b1;
    step(1'b1, 1'b1, 32'h8000_0102);
    step(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      check_val("exc_valid", s_valid, 1);
      check_val("exc_adel", s_adel, 1);
      check_val("exc_inst", s_inst, 0);
      check_val("exc_pc", s_pc, 32'h8000_0102);
      check_val("exc_req", s_req, 0);
    end
    step(1'b0, 1'b1, 32'h8000_0000);
    run_until_pop("exc_resume", 32'h8000_0000);

    // Asynchronous reset with words buffered and in flight
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0);
    check_val("pre_reset_valid", s_valid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_req", ibus_req_o, 0);
    check_val("arst_valid", valid_o, 0);
    check_val("arst_pc", pc_o, 0);
    check_val("arst_inst", inst_o, 0);
    check_val("arst_adel", adel_o, 0);
    resp_q.delete(); resp_t.delete(); exp_q.delete();
    exp_pc = RESET_PC; prev_flush = 1'b0;
    @(negedge clk);
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_until_pop("after_reset", RESET_PC);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
